// File: rtl/apb_timer_pkg.sv
// Shared register offsets and bit positions for the APB timer/PWM peripheral.
// Word indices are PADDR[4:2]; PADDR[1:0] is ignored by the decoder.
package apb_timer_pkg;

   localparam logic [4:0] TMR_CTRL_OFF   = 5'h00;
   localparam logic [4:0] TMR_PRE_OFF    = 5'h04;
   localparam logic [4:0] TMR_LOAD_OFF   = 5'h08;
   localparam logic [4:0] TMR_CMP_OFF    = 5'h0C;
   localparam logic [4:0] TMR_COUNT_OFF  = 5'h10;
   localparam logic [4:0] TMR_STATUS_OFF = 5'h14;

   localparam logic [2:0] TMR_CTRL_IDX   = TMR_CTRL_OFF[4:2];
   localparam logic [2:0] TMR_PRE_IDX    = TMR_PRE_OFF[4:2];
   localparam logic [2:0] TMR_LOAD_IDX   = TMR_LOAD_OFF[4:2];
   localparam logic [2:0] TMR_CMP_IDX    = TMR_CMP_OFF[4:2];
   localparam logic [2:0] TMR_COUNT_IDX  = TMR_COUNT_OFF[4:2];
   localparam logic [2:0] TMR_STATUS_IDX = TMR_STATUS_OFF[4:2];

   localparam int unsigned CTRL_W           = 4;
   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_PWM_EN_BIT  = 1;
   localparam int unsigned CTRL_ONESHOT_BIT = 2;
   localparam int unsigned CTRL_IRQ_EN_BIT  = 3;

   localparam int unsigned STATUS_TMOF_BIT  = 0;

endpackage

// File: rtl/apb_timer_pwm_if.sv
// APB3 bus bundle for the timer/PWM slave; clock and reset stay outside.
interface apb_timer_pwm_if;

   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [4:0]  PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_wait_gen.sv
// APB wait-state generator: holds PREADY low for WAIT_STATES access cycles.
// Reusable by any APB slave; WAIT_STATES = 0 ties PREADY high.
module apb_wait_gen #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic psel_i,
   input  logic penable_i,
   output logic pready_o
);

   localparam logic [2:0] WaitMax = 3'(WAIT_STATES);

   logic [2:0] wait_q, wait_d;
   logic       access;

   assign access = psel_i & penable_i;

   // Idle and setup both clear the count, so an aborted transfer never leaves it stuck.
   always_comb begin
      wait_d = wait_q;
      if (!access) begin
         wait_d = '0;
      end else if (wait_q != WaitMax) begin
         wait_d = wait_q + 3'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   assign pready_o = (WAIT_STATES == 0) ? 1'b1 : (access & (wait_q == WaitMax));

endmodule

// File: rtl/apb_timer_pwm.sv
// 32-bit down-counting timer with prescaler, one-shot/auto-reload, PWM output and
// level interrupt, on an APB3 slave port with configurable wait states.
module apb_timer_pwm
   import apb_timer_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned PRE_W       = 16
) (
   input  logic            PCLK,
   input  logic            PRESET,
   apb_timer_pwm_if.slave  apb,
   output logic            PWM,
   output logic            IRQ
);

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [PRE_W-1:0]  pc_q, pc_d;
   logic [31:0]       load_q, load_d;
   logic [31:0]       cmp_q, cmp_d;
   logic [31:0]       count_q, count_d;
   logic              tmof_q, tmof_d;
   logic              pwm_q, pwm_d;

   logic [2:0]  addr_idx;
   logic        pready, mapped, wr_en, tick, tmof_set;
   logic        wr_ctrl, wr_pre, wr_load, wr_cmp, wr_status;
   logic [31:0] rdata;
   logic        unused_addr_bits;

   apb_wait_gen #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_gen (
      .clk_i     (PCLK),
      .rst_i     (PRESET),
      .psel_i    (apb.PSEL),
      .penable_i (apb.PENABLE),
      .pready_o  (pready)
   );

   assign unused_addr_bits = ^apb.PADDR[1:0];
   assign addr_idx  = apb.PADDR[4:2];
   assign mapped    = (addr_idx <= TMR_STATUS_IDX);
   assign wr_en     = apb.PSEL & apb.PENABLE & pready & apb.PWRITE;
   assign wr_ctrl   = wr_en & (addr_idx == TMR_CTRL_IDX);
   assign wr_pre    = wr_en & (addr_idx == TMR_PRE_IDX);
   assign wr_load   = wr_en & (addr_idx == TMR_LOAD_IDX);
   assign wr_cmp    = wr_en & (addr_idx == TMR_CMP_IDX);
   assign wr_status = wr_en & (addr_idx == TMR_STATUS_IDX);

   assign tick = ctrl_q[CTRL_EN_BIT] & (pc_q == pre_q);

   // Hardware updates first, software writes last so they override.
   always_comb begin
      ctrl_d   = ctrl_q;
      pre_d    = pre_q;
      pc_d     = pc_q;
      load_d   = load_q;
      cmp_d    = cmp_q;
      count_d  = count_q;
      tmof_set = 1'b0;

      if (ctrl_q[CTRL_EN_BIT]) begin
         pc_d = tick ? '0 : pc_q + PRE_W'(1);
      end

      if (tick) begin
         if (count_q == '0) begin
            count_d  = load_q;
            tmof_set = 1'b1;
            if (ctrl_q[CTRL_ONESHOT_BIT]) begin
               ctrl_d[CTRL_EN_BIT] = 1'b0;
            end
         end else begin
            count_d = count_q - 32'd1;
         end
      end

      // A reload in the same cycle as a W1C keeps the flag set.
      tmof_d = tmof_set | (tmof_q & ~(wr_status & apb.PWDATA[STATUS_TMOF_BIT]));

      if (wr_ctrl) begin
         ctrl_d = apb.PWDATA[CTRL_W-1:0];
         if (!ctrl_q[CTRL_EN_BIT] && apb.PWDATA[CTRL_EN_BIT]) begin
            pc_d = '0;
         end
      end
      if (wr_pre) begin
         pre_d = apb.PWDATA[PRE_W-1:0];
      end
      if (wr_load) begin
         load_d  = apb.PWDATA;
         count_d = apb.PWDATA;
         pc_d    = '0;
      end
      if (wr_cmp) begin
         cmp_d = apb.PWDATA;
      end

      pwm_d = ctrl_q[CTRL_EN_BIT] & ctrl_q[CTRL_PWM_EN_BIT] & (count_q < cmp_q);
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         ctrl_q  <= '0;
         pre_q   <= '0;
         pc_q    <= '0;
         load_q  <= '0;
         cmp_q   <= '0;
         count_q <= '0;
         tmof_q  <= 1'b0;
         pwm_q   <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         pre_q   <= pre_d;
         pc_q    <= pc_d;
         load_q  <= load_d;
         cmp_q   <= cmp_d;
         count_q <= count_d;
         tmof_q  <= tmof_d;
         pwm_q   <= pwm_d;
      end
   end

   always_comb begin
      rdata = '0;
      unique case (addr_idx)
         TMR_CTRL_IDX:   rdata[CTRL_W-1:0] = ctrl_q;
         TMR_PRE_IDX:    rdata[PRE_W-1:0]  = pre_q;
         TMR_LOAD_IDX:   rdata             = load_q;
         TMR_CMP_IDX:    rdata             = cmp_q;
         TMR_COUNT_IDX:  rdata             = count_q;
         TMR_STATUS_IDX: rdata[STATUS_TMOF_BIT] = tmof_q;
         default:        rdata             = '0;
      endcase
   end

   assign apb.PRDATA  = (apb.PSEL & ~apb.PWRITE) ? rdata : '0;
   assign apb.PREADY  = pready;
   assign apb.PSLVERR = apb.PSEL & apb.PENABLE & pready & ~mapped;

   assign PWM = pwm_q;
   assign IRQ = tmof_q & ctrl_q[CTRL_IRQ_EN_BIT];

endmodule

// File: tb/tb_apb_timer_pwm.sv
// Self-checking bench for apb_timer_pwm (WAIT_STATES = 2): expected values are queued
// on a scoreboard as stimulus is issued and popped when the DUT output is sampled.
module tb_apb_timer_pwm;
   import apb_timer_pkg::*;

   localparam int unsigned WS = 2;

   logic PCLK = 1'b0;
   logic PRESET;
   logic PWM, IRQ;

   apb_timer_pwm_if bus ();

   apb_timer_pwm #(
      .WAIT_STATES (WS),
      .PRE_W       (16)
   ) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .apb    (bus),
      .PWM    (PWM),
      .IRQ    (IRQ)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          last_waits;
   logic        last_err;
   logic [31:0] last_rdata;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] got);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_eq(e.tag, got, e.val);
      end
   endtask

   task automatic chk_now(input string tag, input logic [31:0] got, input logic [31:0] exp);
      sb_push(tag, exp);
      sb_check(got);
   endtask

   task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata);
      int waits;
      @(negedge PCLK);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = wr;
      bus.PADDR   = addr;
      bus.PWDATA  = wdata;
      @(negedge PCLK);
      bus.PENABLE = 1'b1;
      #1;
      waits = 0;
      while (!bus.PREADY && waits < 16) begin
         @(negedge PCLK);
         #1;
         waits++;
      end
      if (!bus.PREADY) check_eq("pready_timeout", 32'(bus.PREADY), 32'd1);
      last_waits = waits;
      last_rdata = bus.PRDATA;
      last_err   = bus.PSLVERR;
      @(posedge PCLK);
      #1;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
   endtask

   task automatic apb_wr(input logic [4:0] addr, input logic [31:0] data);
      apb_xfer(1'b1, addr, data);
   endtask

   task automatic apb_rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      sb_push(tag, exp);
      apb_xfer(1'b0, addr, 32'h0);
      sb_check(last_rdata);
   endtask

   // Counts high samples and rising edges of PWM over 20 consecutive cycles.
   task automatic pwm_window(output int highs, output int rises);
      logic prev;
      highs = 0;
      rises = 0;
      @(negedge PCLK);
      prev = PWM;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (PWM) highs++;
         if (PWM && !prev) rises++;
         prev = PWM;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          highs, rises;
      logic [31:0] model_cnt;

      PRESET      = 1'b1;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
      bus.PADDR   = '0;
      bus.PWDATA  = '0;

      // Reset values
      #3;
      chk_now("rst_pready", 32'(bus.PREADY), 32'd0);
      chk_now("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
      chk_now("rst_prdata", bus.PRDATA, 32'd0);
      chk_now("rst_pwm", 32'(PWM), 32'd0);
      chk_now("rst_irq", 32'(IRQ), 32'd0);
      repeat (3) @(negedge PCLK);
      PRESET = 1'b0;

      // 1: wait states, LOAD write loads COUNT
      apb_wr(TMR_LOAD_OFF, 32'h10);
      chk_now("t1_waits", 32'(last_waits), 32'(WS));
      apb_rd_chk("t1_count", TMR_COUNT_OFF, 32'h10);
      apb_rd_chk("t1_status", TMR_STATUS_OFF, 32'h0);
      apb_rd_chk("t1_ctrl", TMR_CTRL_OFF, 32'h0);

      // 2: PRE=0, LOAD=3 auto-reload sequence, observed by parking in setup on COUNT
      apb_wr(TMR_PRE_OFF, 32'h0);
      apb_wr(TMR_LOAD_OFF, 32'h3);
      apb_wr(TMR_CTRL_OFF, 32'h1);
      bus.PSEL   = 1'b1;
      bus.PWRITE = 1'b0;
      bus.PADDR  = TMR_COUNT_OFF;
      model_cnt  = 32'd3;
      for (int i = 0; i < 8; i++) begin
         #1;
         sb_push($sformatf("t2_count%0d", i), model_cnt);
         sb_check(bus.PRDATA);
         model_cnt = (model_cnt == 0) ? 32'd3 : model_cnt - 32'd1;
         @(posedge PCLK);
      end
      #1;
      bus.PSEL = 1'b0;
      apb_rd_chk("t2_tmof", TMR_STATUS_OFF, 32'h1);

      // 3: PWM duty with PRE=1, LOAD=4
      apb_wr(TMR_CTRL_OFF, 32'h0);
      apb_wr(TMR_PRE_OFF, 32'h1);
      apb_wr(TMR_LOAD_OFF, 32'h4);
      apb_wr(TMR_CMP_OFF, 32'h2);
      apb_wr(TMR_CTRL_OFF, 32'h3);
      repeat (12) @(negedge PCLK);
      sb_push("t3_pwm_high", 32'd8);
      sb_push("t3_pwm_rises", 32'd2);
      pwm_window(highs, rises);
      sb_check(32'(highs));
      sb_check(32'(rises));
      apb_wr(TMR_CMP_OFF, 32'h0);
      repeat (3) @(negedge PCLK);
      sb_push("t3_cmp0_high", 32'd0);
      pwm_window(highs, rises);
      sb_check(32'(highs));
      apb_wr(TMR_CMP_OFF, 32'h5);
      repeat (3) @(negedge PCLK);
      sb_push("t3_cmp5_high", 32'd20);
      pwm_window(highs, rises);
      sb_check(32'(highs));

      // 4: one-shot clears EN and freezes COUNT at LOAD
      apb_wr(TMR_CTRL_OFF, 32'h0);
      apb_wr(TMR_PRE_OFF, 32'h0);
      apb_wr(TMR_STATUS_OFF, 32'h1);
      apb_wr(TMR_LOAD_OFF, 32'h2);
      apb_wr(TMR_CTRL_OFF, 32'h5);
      repeat (6) @(negedge PCLK);
      apb_rd_chk("t4_ctrl", TMR_CTRL_OFF, 32'h4);
      apb_rd_chk("t4_count", TMR_COUNT_OFF, 32'h2);
      repeat (5) @(negedge PCLK);
      apb_rd_chk("t4_count_frozen", TMR_COUNT_OFF, 32'h2);
      apb_rd_chk("t4_tmof", TMR_STATUS_OFF, 32'h1);

      // 5: IRQ level, set-wins over simultaneous W1C
      apb_wr(TMR_CTRL_OFF, 32'h8);
      chk_now("t5_irq_pending", 32'(IRQ), 32'd1);
      apb_wr(TMR_STATUS_OFF, 32'h1);
      chk_now("t5_irq_cleared", 32'(IRQ), 32'd0);
      apb_wr(TMR_LOAD_OFF, 32'h3);
      apb_wr(TMR_CTRL_OFF, 32'h9);
      // Commits 4 cycles later, exactly on the 0->3 reload tick
      apb_wr(TMR_STATUS_OFF, 32'h1);
      chk_now("t5_set_wins", 32'(IRQ), 32'd1);
      apb_wr(TMR_CTRL_OFF, 32'h8);
      apb_wr(TMR_STATUS_OFF, 32'h1);
      chk_now("t5_irq_low", 32'(IRQ), 32'd0);
      apb_rd_chk("t5_status", TMR_STATUS_OFF, 32'h0);

      // 6: unmapped offsets
      apb_wr(5'h1C, 32'hF);
      chk_now("t6_wr_slverr", 32'(last_err), 32'd1);
      apb_rd_chk("t6_ctrl_intact", TMR_CTRL_OFF, 32'h8);
      chk_now("t6_mapped_noerr", 32'(last_err), 32'd0);
      apb_rd_chk("t6_unmapped_rd", 5'h18, 32'h0);
      chk_now("t6_rd_slverr", 32'(last_err), 32'd1);

      // 6: reset in the middle of an access
      apb_wr(TMR_LOAD_OFF, 32'h3);
      apb_wr(TMR_CMP_OFF, 32'h5);
      apb_wr(TMR_CTRL_OFF, 32'hB);
      repeat (8) @(negedge PCLK);
      chk_now("t6_pwm_pre", 32'(PWM), 32'd1);
      chk_now("t6_irq_pre", 32'(IRQ), 32'd1);
      @(negedge PCLK);
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
      bus.PADDR   = TMR_LOAD_OFF;
      @(negedge PCLK);
      bus.PENABLE = 1'b1;
      @(negedge PCLK);
      #1;
      chk_now("t6_prdata_pre", bus.PRDATA, 32'h3);
      PRESET = 1'b1;
      #1;
      chk_now("t6_rst_pwm", 32'(PWM), 32'd0);
      chk_now("t6_rst_irq", 32'(IRQ), 32'd0);
      chk_now("t6_rst_prdata", bus.PRDATA, 32'h0);
      chk_now("t6_rst_pready", 32'(bus.PREADY), 32'd0);
      chk_now("t6_rst_pslverr", 32'(bus.PSLVERR), 32'd0);
      @(negedge PCLK);
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      apb_wr(TMR_LOAD_OFF, 32'h7);
      chk_now("t6_post_waits", 32'(last_waits), 32'(WS));
      apb_rd_chk("t6_post_load", TMR_LOAD_OFF, 32'h7);
      apb_rd_chk("t6_post_ctrl", TMR_CTRL_OFF, 32'h0);

      chk_now("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
